// File: rtl/bit_encoder_pkg.sv
// Shared types and default sizing for the bit_encoder slice.
// Scan order is selected with BIT_ENCODER_MSB_FIRST_EN (see prio_find).
package bit_encoder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } enc_state_t;

   localparam int DEF_N = 16;
   localparam int DEF_W = 4;

endpackage

// File: rtl/bit_encoder_prio_find.sv
// Combinational priority finder: index of the first set bit plus an any-set flag.
// BIT_ENCODER_MSB_FIRST_EN defined: highest index wins; otherwise lowest index wins.
module prio_find #(
   parameter int N = bit_encoder_pkg::DEF_N,
   parameter int W = bit_encoder_pkg::DEF_W
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   // The first set bit met in scan order is the winner; an empty vector yields index 0.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
`ifdef BIT_ENCODER_MSB_FIRST_EN
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i] && !o_any) begin
            o_idx = W'(i);
            o_any = 1'b1;
         end
      end
`else
      for (int i = 0; i < N; i++) begin
         if (i_vec[i] && !o_any) begin
            o_idx = W'(i);
            o_any = 1'b1;
         end
      end
`endif
   end

endmodule

// File: rtl/bit_encoder.sv
// Sequential N-to-W encoder: captures a multi-hot vector and emits one index per handshake.
// BIT_ENCODER_MSB_FIRST_EN reverses the scan order (applied inside prio_find).
module bit_encoder
   import bit_encoder_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] d,
   input  logic         en,
   output logic [W-1:0] q,
   output logic         valid,
   input  logic         ready,
   output logic         busy,
   output logic         done
);

   enc_state_t   r_state;
   enc_state_t   w_nextState;
   logic [N-1:0] r_pend;
   logic         r_done;

   logic [W-1:0] w_idx;
   logic         w_any;
   logic         w_load;
   logic         w_hs;
   logic [N-1:0] w_pendCleared;

   prio_find #(
      .N (N),
      .W (W)
   ) u_prioFind (
      .i_vec (r_pend),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_load        = (r_state == IDLE) && en;
   assign w_hs          = (r_state == SCAN) && w_any && ready;
   assign w_pendCleared = r_pend & ~(N'(1) << w_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (en && (d != '0)) w_nextState = SCAN;
         SCAN:    if (w_hs && (w_pendCleared == '0)) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // done fires once per drained vector, including the empty-vector case.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (w_load && (d == '0)) || (w_hs && (w_pendCleared == '0));
         if (w_load) begin
            r_pend <= d;
         end else if (w_hs) begin
            r_pend <= w_pendCleared;
         end
      end
   end

   always_comb begin
      valid = (r_state == SCAN);
      busy  = (r_state == SCAN);
      q     = w_idx;
      done  = r_done;
   end

endmodule

// File: tb/tb_bit_encoder.sv
// Self-checking bench for bit_encoder using an index scoreboard.
// Honours BIT_ENCODER_MSB_FIRST_EN for the expected scan order.
module tb_bit_encoder;

   logic        clk;
   logic        rst_n;
   logic [15:0] d;
   logic        en;
   logic [3:0]  q;
   logic        valid;
   logic        ready;
   logic        busy;
   logic        done;

   int          checks;
   int          errors;
   int          expDone;
   int          doneSeen;
   logic [3:0]  expQ[$];

   bit_encoder #(
      .N (16),
      .W (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .en    (en),
      .q     (q),
      .valid (valid),
      .ready (ready),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Expected index sequence for a vector, in the configured scan order.
   task automatic pushVector(input logic [15:0] v);
`ifdef BIT_ENCODER_MSB_FIRST_EN
      for (int i = 15; i >= 0; i--) if (v[i]) expQ.push_back(4'(i));
`else
      for (int i = 0; i < 16; i++) if (v[i]) expQ.push_back(4'(i));
`endif
   endtask

   task automatic applyStimulus(input logic [15:0] v);
      d  = v;
      en = 1'b1;
      pushVector(v);
      expDone++;
      waitCycle();
      en = 1'b0;
   endtask

   // Scoreboard: every accepted index is compared against the oldest expected one.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid && ready) begin
            if (expQ.size() == 0) checkOutput("sbEmptyValid", {31'b0, valid}, 32'd0);
            else                  checkOutput("qIndex", {28'b0, q}, {28'b0, expQ.pop_front()});
         end
         if (done) doneSeen++;
      end
   end

   initial begin
      int cyc;
      logic [3:0] held;
      checks   = 0;
      errors   = 0;
      expDone  = 0;
      doneSeen = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      ready    = 1'b0;
      d        = '0;

      #12;
      checkOutput("rstValid", {31'b0, valid}, 32'd0);
      checkOutput("rstBusy",  {31'b0, busy},  32'd0);
      checkOutput("rstDone",  {31'b0, done},  32'd0);
      checkOutput("rstQ",     {28'b0, q},     32'd0);
      rst_n = 1'b1;
      waitCycle();

      // Multi-bit vector drained at full rate.
      ready = 1'b1;
      applyStimulus(16'h8421);
      checkOutput("loadValid", {31'b0, valid}, 32'd1);
      checkOutput("loadBusy",  {31'b0, busy},  32'd1);
      repeat (4) waitCycle();
      checkOutput("drainDone",  {31'b0, done},  32'd1);
      checkOutput("drainBusy",  {31'b0, busy},  32'd0);
      checkOutput("drainValid", {31'b0, valid}, 32'd0);
      checkOutput("drainSb",    expQ.size(),    32'd0);
      waitCycle();
      checkOutput("donePulse", {31'b0, done}, 32'd0);

      // Backpressure holds q and valid.
      ready = 1'b0;
      applyStimulus(16'h0006);
      held = expQ[0];
      for (int i = 0; i < 3; i++) begin
         checkOutput("stallQ",     {28'b0, q},     {28'b0, held});
         checkOutput("stallValid", {31'b0, valid}, 32'd1);
         waitCycle();
      end
      ready = 1'b1;
      repeat (2) waitCycle();
      checkOutput("stallDone", {31'b0, done}, 32'd1);
      waitCycle();

      // Empty vector: immediate done, no valid.
      applyStimulus(16'h0000);
      checkOutput("zeroDone",  {31'b0, done},  32'd1);
      checkOutput("zeroValid", {31'b0, valid}, 32'd0);
      checkOutput("zeroBusy",  {31'b0, busy},  32'd0);
      waitCycle();
      checkOutput("zeroDoneOnce", {31'b0, done},  32'd0);
      checkOutput("zeroValid2",   {31'b0, valid}, 32'd0);

      // Load attempted while busy must be ignored.
      applyStimulus(16'h0003);
      d  = 16'hFFFF;
      en = 1'b1;
      waitCycle();
      en = 1'b0;
      waitCycle();
      checkOutput("ignoreDone", {31'b0, done}, 32'd1);
      checkOutput("ignoreBusy", {31'b0, busy}, 32'd0);
      waitCycle();
      checkOutput("ignoreValid", {31'b0, valid}, 32'd0);

      // Back-to-back loads issued in each done cycle.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(16'(i));
         cyc = 0;
         while (!done && cyc < 20) begin
            waitCycle();
            cyc++;
         end
         checkOutput("loopDone",    {31'b0, done}, 32'd1);
         checkOutput("loopLatency", cyc,           $countones(16'(i)));
      end
      waitCycle();

      // Reset in the middle of a scan discards everything.
      d  = 16'hF000;
      en = 1'b1;
      pushVector(16'hF000);
      waitCycle();
      en = 1'b0;
      waitCycle();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstValid", {31'b0, valid}, 32'd0);
      checkOutput("midRstBusy",  {31'b0, busy},  32'd0);
      checkOutput("midRstDone",  {31'b0, done},  32'd0);
      expQ.delete();
      #3;
      rst_n = 1'b1;
      repeat (4) begin
         waitCycle();
         checkOutput("postRstValid", {31'b0, valid}, 32'd0);
         checkOutput("postRstDone",  {31'b0, done},  32'd0);
      end

      checkOutput("doneCount", doneSeen,    expDone);
      checkOutput("sbDrained", expQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_encoder.md
# bit_encoder

Sequential 16-to-4 encoder: the inverse of the 4-to-16 `decoder`. It captures a multi-hot input vector on an enable strobe and emits the 4-bit index of every set bit, one index per accepted transfer, over a valid/ready handshake. It sits where a set of request or flag lines must be turned back into indices, for example for a downstream `decoder` or for a serial consumer.

## Interface
Parameters:
- `N`, default 16: input vector width; must be a power of two, at least 2.
- `W`, default 4: index width; must equal $clog2(N).

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst_n`  in  1  Reset, asynchronous and active-low.
- `d`  in  N  Input vector; sampled only on a load.
- `en`  in  1  Load strobe; a load happens on any edge where `en`=1 and `busy`=0.
- `q`  out  W  Index of the current pending bit; meaningful only while `valid`=1.
- `valid`  out  1  `q` holds an index.
- `ready`  in  1  Consumer accepts `q` on any edge where `valid`=1 and `ready`=1.
- `busy`  out  1  A vector is loaded and not yet fully drained.
- `done`  out  1  One-cycle pulse after the vector is drained, including after an all-zero load.

## Operation
- State `IDLE`:
  - On `en`=1, register `pend <= d`.
  - If `d`≠0, go to `SCAN`.
  - If `d`=0, stay in `IDLE` and set `done`=1 on the next cycle.
- State `SCAN`:
  - `valid`=1, `busy`=1.
  - `q` = index of the lowest set bit of `pend`, or the highest with `MSB_FIRST` (see Configuration). `q` is combinational from the `pend` register.
  - On a handshake, clear that bit in `pend`.
  - If the cleared bit was the last one, go to `IDLE` and set `done`=1 for exactly one cycle.
- `en` while `busy`=1 is ignored; the captured vector is unchanged.
- While `ready`=0, `q` and `valid` stay stable.
- `done` is asserted only for one cycle and needs no acknowledge.
- Reset values:
  - state `IDLE`, `pend`=0
  - `valid`=0, `busy`=0, `done`=0
  - `q`=0, since `q` decodes from `pend`=0
- Reset mid-scan discards all pending indices; no `done` is produced.

## Timing
- Load to first `valid`: 1 cycle. `en` is sampled at edge E, and `valid` rises after E.
- With `ready` held high, one index per cycle. A vector with k set bits drains in k cycles.
- `done` rises after the edge that accepts the final index. `busy` falls at the same time.
- A new load is accepted in the same cycle `done`=1, because `busy`=0 then.
- All-zero load: `done`=1 in the cycle after the load edge, and `valid` never asserts.
- Minimum period from load to load: k+1 cycles for k≥1 set bits, 1 cycle for k=0.
- No combinational path from `ready` or `en` to any output.

## Configuration
- `BIT_ENCODER_MSB_FIRST_EN`:
  - Defined: the scan order is highest index first.
  - Undefined (default): the scan order is lowest index first.
- The macro only reverses the priority finder. The handshake and all timing are unchanged.

## Structure
- Package `bit_encoder_pkg`:
  - enum `enc_state_t` {`IDLE`, `SCAN`}
  - localparams for the default `N`/`W`
- One sub-module, `prio_find`:
  - Combinational, parameterised by `N`/`W`.
  - Input: a vector. Outputs: the index of the first set bit and an `any` flag.
  - The order is selected by the macro.
- The top level holds the state register, the `pend` register, the bit-clear logic and the `done` flop.

## Test plan
- Reset, then `d`=16'h8421 with an `en` pulse and `ready`=1:
  - `q` = 0, 5, 10, 15 on 4 consecutive cycles, `valid`=1 throughout.
  - `done` pulses on the 5th cycle, then `busy`=0.
  - With `BIT_ENCODER_MSB_FIRST_EN`: `q` = 15, 10, 5, 0.
- Backpressure: `d`=16'h0006, `ready`=0 for 3 cycles, then 1:
  - `q` holds 1 with `valid`=1 while stalled.
  - Then `q`=2, then `done`.
- `d`=16'h0000 with an `en` pulse:
  - `valid` stays 0.
  - `done`=1 for exactly one cycle, the cycle after load.
- `en` with `d`=16'hFFFF while draining 16'h0003:
  - Only indices 0 and 1 are emitted.
  - The second vector is not captured.
- Loop `d`=i for i=0..15 with `en` re-asserted in each `done` cycle:
  - Every `q` equals the single set-bit index of the one-hot values.
  - Zero-handling holds for i=0.
- Reset mid-scan of 16'hF000 after one handshake:
  - `valid`, `busy` and `done` go to 0 immediately.
  - No further `q` is emitted.
